// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Streams bytes from a valid/ready source into an instruction
//               RAM byte port. Assembles little-endian 32-bit words, keeps a
//               running mod-256 checksum and holds the CPU stalled (busy)
//               for the duration of the load.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   byte_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [31:0]           word_out,
  output logic                  word_valid,
  output logic [7:0]            checksum,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest legal load is the whole RAM (2^ADDR_WIDTH bytes).
  localparam logic [ADDR_WIDTH:0]   MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [1:0]            lane;
  logic [31:0]           word_acc;
  logic [31:0]           word_merged;
  logic [7:0]            in_byte;
  logic                  accept;
  logic                  last_byte;
  logic                  count_ok;

  assign in_byte   = 8'(in_data);
  assign in_ready  = (state == LOAD) && (remaining != '0);
  assign accept    = in_ready && in_valid;
  assign last_byte = (remaining == CNT_ONE);
  assign count_ok  = (byte_count != '0) && (byte_count <= MAX_COUNT);
  assign busy      = (state != IDLE);

  // Drop the incoming byte into its lane of the partially assembled word.
  always_comb begin
    word_merged = word_acc;
    word_merged[8*lane +: 8] = in_byte;
  end

  // Load sequencer: start/reject, byte acceptance, word assembly and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      next_addr  <= '0;
      remaining  <= '0;
      lane       <= 2'd0;
      word_acc   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      checksum   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      word_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count_ok) begin
              next_addr <= base_addr;
              remaining <= byte_count;
              lane      <= 2'd0;
              word_acc  <= '0;
              checksum  <= '0;
              state     <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_en     <= 1'b1;
            wr_addr   <= next_addr;
            wr_data   <= in_data;
            next_addr <= next_addr + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
            lane      <= lane + 2'd1;
            checksum  <= checksum + in_byte;
            // Publish on a full word, or on a trailing partial word whose
            // unfilled upper lanes are still zero from the last clear.
            if (lane == 2'd3 || last_byte) begin
              word_out   <= word_merged;
              word_valid <= 1'b1;
              word_acc   <= '0;
            end else begin
              word_acc <= word_merged;
            end
            if (last_byte) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          // A start seen here is deliberately dropped.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the byte-address width of the target instruction RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the byte-lane width of the RAM write port.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-006 SHALL have port base_addr, input, ADDR_WIDTH, the first byte address written; sampled on accepted start.
REQ-007 SHALL have port byte_count, input, ADDR_WIDTH+1, the number of bytes to load (legal 1..256); sampled on accepted start.
REQ-008 SHALL have port in_valid, input, 1, the source has a byte on in_data.
REQ-009 SHALL have port in_data, input, DATA_WIDTH, the stream byte.
REQ-010 SHALL have port in_ready, output, 1, the loader accepts in_data this cycle.
REQ-011 SHALL have port wr_en, output, 1, the RAM byte write strobe.
REQ-012 SHALL have port wr_addr, output, ADDR_WIDTH, the RAM byte address.
REQ-013 SHALL have port wr_data, output, DATA_WIDTH, the RAM byte data.
REQ-014 SHALL have port word_out, output, 32, the last assembled little-endian instruction word.
REQ-015 SHALL have port word_valid, output, 1, a one-cycle pulse qualifying word_out.
REQ-016 SHALL have port checksum, output, 8, the mod-256 sum of bytes loaded in the current or last load.
REQ-017 SHALL have port busy, output, 1, high in LOAD; the CPU is held in stall while high.
REQ-018 SHALL have port done, output, 1, a one-cycle pulse on load completion.
REQ-019 SHALL have port err, output, 1, a one-cycle pulse on a rejected start.

Function
REQ-020 SHALL implement states IDLE, LOAD and DONE.
REQ-021 In IDLE, start with 1 <= byte_count <= 256 SHALL latch base_addr and byte_count, clear checksum and the word assembler, and go to LOAD next cycle.
REQ-022 In IDLE, start with byte_count = 0 or > 256 SHALL pulse err next cycle and remain in IDLE.
REQ-023 start outside IDLE SHALL be ignored, with no err.
REQ-024 in_ready SHALL be 1 exactly when in LOAD and bytes remain; a byte is accepted when in_valid and in_ready are both 1.
REQ-025 Each accepted byte SHALL appear one cycle later as wr_en=1, with wr_data equal to the byte and wr_addr = base_addr + k (mod 2^ADDR_WIDTH, wrapping 0xFF->0x00), k = 0-based byte index.
REQ-026 wr_en SHALL be 0 in every cycle that follows no acceptance; in_valid gaps SHALL stall without losing position.
REQ-027 Byte k SHALL be placed in word bits [8*(k%4)+7 : 8*(k%4)]; when k%4 = 3, word_valid SHALL pulse with word_out, aligned with that byte's wr_en.
REQ-028 If the final byte leaves a partial word, word_valid SHALL pulse with the unfilled upper bytes zero.
REQ-029 checksum SHALL update by +in_data (mod 256) on each acceptance and hold after completion until the next accepted start.
REQ-030 After the final byte is accepted, the state SHALL go to DONE; done SHALL pulse for one cycle aligned with the final wr_en; the state SHALL then return to IDLE.
REQ-031 busy SHALL be 1 in LOAD and DONE, and 0 in IDLE.
REQ-032 start in the same cycle as done SHALL be ignored; start is accepted from the following IDLE cycle.

Reset
REQ-033 rst_n low SHALL immediately force IDLE; in_ready, wr_en, word_valid, done, err and busy SHALL be 0; wr_addr, wr_data, word_out and checksum SHALL be 0.
REQ-034 Reset mid-LOAD SHALL abandon the load with no further writes; after release, a new start SHALL be required.

Verification
REQ-035 Load 4 bytes 13,05,00,00 at base 0x00 with in_valid held high -> writes to addresses 0..3 on consecutive cycles, word_out=0x00000513 with word_valid, checksum=0x18, and done on the 4th write.
REQ-036 Load 6 bytes at base 0xFE -> wr_addr sequence FE,FF,00,01,02,03; two word_valid pulses; the second word has upper 16 bits zero.
REQ-037 in_valid toggled 1,0,0,1 during the load -> wr_en only follows accepted cycles, and the address/index does not advance on gaps.
REQ-038 start with byte_count=0, then with byte_count=257 -> err pulses each time, no wr_en, busy stays 0.
REQ-039 rst_n asserted after 2 of 8 bytes -> all outputs 0 asynchronously, no further wr_en; a new start loads cleanly from its base.
REQ-040 start pulsed during LOAD and again coincident with done -> both ignored; the original load completes unchanged.
